// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
//
// Eight-requester round-robin arbiter for one shared resource. It issues a
// registered one-hot grant together with the 3-bit binary index of the owner,
// so the index can steer the shared 8-to-3 select path with no extra encoder.
// Ownership is sequenced IDLE -> OWN -> GAP, which puts exactly one dead cycle
// (grant all zero) between any two owners, including a requester that is
// granted twice in a row.
//
// Optional feature (compile-time macro): HOLD_TIMEOUT_EN
//   Defined     : an owner that keeps its request high for MAX_HOLD cycles
//                 is revoked, and o_timeout pulses for the GAP cycle.
//   Not defined : ownership is unlimited, no hold counter exists and
//                 o_timeout is tied low.
//
// Parameters
//   N_REQ    : number of requesters (fixed at 8, the index is 3 bits wide)
//   MAX_HOLD : hold limit in cycles, 1..255 (used only with HOLD_TIMEOUT_EN)
//
// Ports
//   i_clk         : system clock, all logic on the rising edge
//   i_reset       : synchronous, active-high reset
//   i_req         : level-sensitive request vector, bit i = requester i
//   o_grant       : registered one-hot grant, zero when there is no owner
//   o_grant_idx   : binary index of the granted bit, 0 when there is no owner
//   o_grant_valid : high whenever o_grant is non-zero
//   o_timeout     : one-cycle pulse when an owner is revoked by the hold limit
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_grant,
  output logic [2:0]       o_grant_idx,
  output logic             o_grant_valid,
  output logic             o_timeout
);

  localparam logic [7:0] L_MAX_HOLD = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_ptr;
  logic [2:0]       w_ptr_next;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_grant_next;
  logic [2:0]       r_grant_idx;
  logic [2:0]       w_grant_idx_next;

  logic             w_any_req;
  logic [2:0]       w_win_idx;
  logic [N_REQ-1:0] w_win_onehot;
  logic             w_owner_req;
  logic             w_hold_expired;

  assign w_any_req   = |i_req;
  assign w_owner_req = i_req[r_grant_idx];

  // Rotating priority search. Candidates are ptr+1 .. ptr+8 (mod 8); walking
  // from the farthest back to the nearest lets the nearest set bit win, so
  // ptr+1 is highest priority and the previous owner (ptr+8 == ptr) lowest.
  // The 3-bit add wraps 7 -> 0 on its own.
  always_comb begin
    w_win_idx = r_ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req[3'(r_ptr + 3'(k))]) begin
        w_win_idx = 3'(r_ptr + 3'(k));
      end
    end
  end

  always_comb begin
    w_win_onehot            = '0;
    w_win_onehot[w_win_idx] = 1'b1;
  end

`ifdef HOLD_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic       r_timeout;

  // The counter reads 0 during the first OWN cycle and advances once per
  // further OWN cycle, so "count + 1" is the number of cycles already owned
  // at the closing edge. Revoking when that reaches MAX_HOLD gives the owner
  // exactly MAX_HOLD cycles of grant.
  assign w_hold_expired = (r_state == OWN) && ((r_hold_cnt + 8'd1) == L_MAX_HOLD);

  // Cleared whenever the arbiter is not continuing an ownership, which also
  // makes it zero on every entry into OWN.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hold_cnt <= 8'd0;
    end else if ((r_state == OWN) && (w_state_next == OWN)) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end else begin
      r_hold_cnt <= 8'd0;
    end
  end

  // The pulse is raised only for a genuine revocation: if the owner drops
  // its request on the same edge the limit is reached, it is a normal release.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_hold_expired && w_owner_req;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_max_hold;

  // Without the hold limit the parameter has no function; it is folded into
  // a deliberately unused net so the configuration stays visible.
  assign w_unused_max_hold = ^L_MAX_HOLD;
  assign w_hold_expired    = 1'b0;
  assign o_timeout         = 1'b0;
`endif

  // Next-state and next-output logic. Grant and index are computed here and
  // registered below, so the outputs change only on clock edges.
  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_grant_next     = r_grant;
    w_grant_idx_next = r_grant_idx;

    case (r_state)
      // GAP shares the IDLE arbitration, so a waiting requester is granted
      // straight out of the single dead cycle.
      IDLE, GAP: begin
        if (w_any_req) begin
          w_state_next     = OWN;
          w_grant_next     = w_win_onehot;
          w_grant_idx_next = w_win_idx;
        end else begin
          w_state_next     = IDLE;
          w_grant_next     = '0;
          w_grant_idx_next = 3'd0;
        end
      end

      // No preemption: other requests are ignored until the owner releases
      // or is revoked. The owner becomes the new pointer, making it the
      // lowest-priority candidate in the next arbitration.
      OWN: begin
        if (!w_owner_req || w_hold_expired) begin
          w_state_next     = GAP;
          w_ptr_next       = r_grant_idx;
          w_grant_next     = '0;
          w_grant_idx_next = 3'd0;
        end
      end

      default: begin
        w_state_next     = IDLE;
        w_grant_next     = '0;
        w_grant_idx_next = 3'd0;
      end
    endcase
  end

  // Pointer resets to 7 so that requester 0 is first in line after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_ptr       <= 3'd7;
      r_grant     <= '0;
      r_grant_idx <= 3'd0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_grant     <= w_grant_next;
      r_grant_idx <= w_grant_idx_next;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_idx   = r_grant_idx;
  assign o_grant_valid = |r_grant;

endmodule

// File: tb/tb_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter8
//
// Directed self-checking bench for rr_arbiter8. Each step drives the request
// and reset inputs, records the outputs expected after the next rising edge,
// and checks them 1 time unit after that edge. Expected grants are written
// out by hand from the arbitration rules; index and valid are derived from
// the expected grant. Build with HOLD_TIMEOUT_EN defined to exercise the
// hold limit (the DUT is instantiated with MAX_HOLD=4).
// ---------------------------------------------------------------------------
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grantIdx;
  logic       grantValid;
  logic       timeoutOut;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic [7:0] grant;
    logic       timeout;
  } exp_t;

  exp_t  expQ[$];
  string tagQ[$];

  rr_arbiter8 #(
    .N_REQ   (8),
    .MAX_HOLD(4)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .o_grant      (grant),
    .o_grant_idx  (grantIdx),
    .o_grant_valid(grantValid),
    .o_timeout    (timeoutOut)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] encodeIdx(input logic [7:0] g);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (g[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Pops the oldest expectation and compares all four outputs against it.
  task automatic checkOutput();
    exp_t       e;
    string      t;
    logic [2:0] expIdx;
    logic       expValid;
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard-empty observed=0 entries required=1");
      return;
    end
    e        = expQ.pop_front();
    t        = tagQ.pop_front();
    expIdx   = encodeIdx(e.grant);
    expValid = |e.grant;

    testsRun++;
    assert (grant === e.grant) else begin
      testsFailed++;
      $error("[TB] FAIL %s grant observed=%h expected=%h", t, grant, e.grant);
    end
    testsRun++;
    assert (grantIdx === expIdx) else begin
      testsFailed++;
      $error("[TB] FAIL %s grant_idx observed=%0d expected=%0d", t, grantIdx, expIdx);
    end
    testsRun++;
    assert (grantValid === expValid) else begin
      testsFailed++;
      $error("[TB] FAIL %s grant_valid observed=%b expected=%b", t, grantValid, expValid);
    end
    testsRun++;
    assert (timeoutOut === e.timeout) else begin
      testsFailed++;
      $error("[TB] FAIL %s timeout observed=%b expected=%b", t, timeoutOut, e.timeout);
    end
  endtask

  // Drives one cycle of stimulus, queues what must appear after the edge,
  // then checks it just after that edge.
  task automatic applyStimulus(input logic [7:0] r, input logic rst,
                               input logic [7:0] expGrant, input logic expTimeout,
                               input string tag);
    exp_t e;
    req          = r;
    reset        = rst;
    e.grant      = expGrant;
    e.timeout    = expTimeout;
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [7:0] own;
    logic [7:0] nxt;
    reset = 1'b1;
    req   = 8'h00;

    // Reset held for two cycles with every requester active.
    applyStimulus(8'hFF, 1'b1, 8'h00, 1'b0, "reset-1");
    applyStimulus(8'hFF, 1'b1, 8'h00, 1'b0, "reset-2");
    applyStimulus(8'hFF, 1'b0, 8'h01, 1'b0, "reset-release");

    // Full rotation: each owner holds 3 cycles, drops its bit for one cycle.
    for (int i = 0; i < 8; i++) begin
      own = 8'h01 << i;
      nxt = 8'h01 << ((i + 1) % 8);
      applyStimulus(8'hFF, 1'b0, own, 1'b0, $sformatf("rotate-hold-a%0d", i));
      applyStimulus(8'hFF, 1'b0, own, 1'b0, $sformatf("rotate-hold-b%0d", i));
      applyStimulus(8'hFF & ~own, 1'b0, 8'h00, 1'b0, $sformatf("rotate-gap%0d", i));
      applyStimulus(8'hFF, 1'b0, nxt, 1'b0, $sformatf("rotate-next%0d", i));
    end

    // Move ownership to requester 5, then sparse requests 7 and 2.
    applyStimulus(8'h20, 1'b0, 8'h00, 1'b0, "to5-gap");
    applyStimulus(8'h20, 1'b0, 8'h20, 1'b0, "to5-grant");
    applyStimulus(8'h20, 1'b0, 8'h20, 1'b0, "to5-hold");
    applyStimulus(8'h84, 1'b0, 8'h00, 1'b0, "sparse-gap5");
    applyStimulus(8'h84, 1'b0, 8'h80, 1'b0, "sparse-grant7");
    applyStimulus(8'h04, 1'b0, 8'h00, 1'b0, "sparse-gap7");
    applyStimulus(8'h04, 1'b0, 8'h04, 1'b0, "sparse-wrap2");

    // No preemption: requester 3 owns while 0 and 6 raise requests.
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b0, "nopre-gap2");
    applyStimulus(8'h08, 1'b0, 8'h08, 1'b0, "nopre-grant3");
    applyStimulus(8'h49, 1'b0, 8'h08, 1'b0, "nopre-hold-a");
    applyStimulus(8'h49, 1'b0, 8'h08, 1'b0, "nopre-hold-b");
    applyStimulus(8'h41, 1'b0, 8'h00, 1'b0, "nopre-gap3");
    applyStimulus(8'h41, 1'b0, 8'h40, 1'b0, "nopre-grant6");

    // Reset while requester 4 owns; pointer must return to 7.
    applyStimulus(8'h10, 1'b0, 8'h00, 1'b0, "midrst-gap6");
    applyStimulus(8'h10, 1'b0, 8'h10, 1'b0, "midrst-grant4");
    applyStimulus(8'h10, 1'b1, 8'h00, 1'b0, "midrst-reset");
    applyStimulus(8'h11, 1'b0, 8'h01, 1'b0, "midrst-grant0");
    applyStimulus(8'h11, 1'b0, 8'h01, 1'b0, "midrst-hold0");

    // Single requester re-granted after the dead cycle, then idle.
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, "single-gap");
    applyStimulus(8'h01, 1'b0, 8'h01, 1'b0, "single-regrant");
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, "single-gap2");
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, "idle-1");
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, "idle-2");

    // Requester 0 never releases while requester 1 waits.
    applyStimulus(8'h00, 1'b1, 8'h00, 1'b0, "hold-reset");
    applyStimulus(8'h03, 1'b0, 8'h01, 1'b0, "hold-c1");
    applyStimulus(8'h03, 1'b0, 8'h01, 1'b0, "hold-c2");
    applyStimulus(8'h03, 1'b0, 8'h01, 1'b0, "hold-c3");
    applyStimulus(8'h03, 1'b0, 8'h01, 1'b0, "hold-c4");
`ifdef HOLD_TIMEOUT_EN
    applyStimulus(8'h03, 1'b0, 8'h00, 1'b1, "hold-revoke");
    applyStimulus(8'h03, 1'b0, 8'h02, 1'b0, "hold-grant1");
    applyStimulus(8'h03, 1'b0, 8'h02, 1'b0, "hold-keep1");
    applyStimulus(8'h01, 1'b0, 8'h00, 1'b0, "hold-gap1");
    applyStimulus(8'h01, 1'b0, 8'h01, 1'b0, "hold-regrant0");
`else
    applyStimulus(8'h03, 1'b0, 8'h01, 1'b0, "hold-c5");
    applyStimulus(8'h03, 1'b0, 8'h01, 1'b0, "hold-c6");
    applyStimulus(8'h03, 1'b0, 8'h01, 1'b0, "hold-c7");
    applyStimulus(8'h02, 1'b0, 8'h00, 1'b0, "hold-gap0");
    applyStimulus(8'h02, 1'b0, 8'h02, 1'b0, "hold-grant1");
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
